// File: rtl/psum_pkg.sv
// Shared constants, FSM encoding and lane post-processing
// for the partial-sum accumulator.
package psum_pkg;

    localparam int O      = 32;
    localparam int K      = 22;
    localparam int ACC_W  = 32;
    localparam int B_W    = 16;
    localparam int OUT_W  = 8;
    localparam int PASS_W = 8;
    localparam int SH_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Rounding arithmetic shift, ReLU, then unsigned saturation.
    // One guard bit keeps acc + rounding term from wrapping.
    function automatic logic [OUT_W-1:0] lane_out(
        input logic signed [ACC_W-1:0] acc,
        input logic [SH_W-1:0]         shift
    );
        logic signed [ACC_W:0] one;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] r;
        logic [OUT_W-1:0]      y;
        one   = {{ACC_W{1'b0}}, 1'b1};
        max_v = {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};
        rnd   = '0;
        if (shift != '0)
            rnd = one <<< (shift - 1'b1);
        sum = {acc[ACC_W-1], acc} + rnd;
        r   = sum >>> shift;
        if (r[ACC_W])
            y = '0;
        else if (r > max_v)
            y = '1;
        else
            y = r[OUT_W-1:0];
        return y;
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One filter lane: accumulator plus bias add and output register,
// sequenced by strobes from the top-level FSM.
module psum_lane
    import psum_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc_en,
    input  logic             bias_en,
    input  logic             out_en,
    input  logic [K-1:0]     partial,
    input  logic [B_W-1:0]   bias,
    input  logic [SH_W-1:0]  shift,
    output logic [OUT_W-1:0] dout
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] part_x;
    logic signed [ACC_W-1:0] bias_x;

    assign part_x = {{(ACC_W-K){partial[K-1]}}, partial};
    assign bias_x = {{(ACC_W-B_W){bias[B_W-1]}}, bias};

    // Accumulator: cleared per pixel, sums beats, then adds bias once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + part_x;
        else if (bias_en)
            acc <= acc + bias_x;
    end

    // Output byte only changes on the OUT cycle, so it holds between pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else if (out_en)
            dout <= lane_out(acc, shift);
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator top: pixel FSM, pass counter, beat
// validity checking and the lane array.
module psum_accum
    import psum_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [PASS_W-1:0]  cfg_passes,
    input  logic [SH_W-1:0]    cfg_shift,
    input  logic [B_W*O-1:0]   bias,
    input  logic [K*O-1:0]     partial,
    input  logic [O-1:0]       vld_i,
    output logic [OUT_W*O-1:0] dout,
    output logic               dout_vld,
    output logic               busy,
    output logic               err
);

    state_t              state;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   pass_cnt;
    logic [SH_W-1:0]     shift_q;
    logic                full_beat;
    logic                mixed;
    logic                start;
    logic                acc_en;
    logic                last_beat;
    logic                bias_en;
    logic                out_en;

    assign full_beat = &vld_i;
    assign mixed     = (|vld_i) & ~full_beat;
    assign start     = cfg_start & (state == S_IDLE);
    assign acc_en    = full_beat & (state == S_ACCUM);
    assign last_beat = acc_en & (pass_cnt == passes_q - 8'd1);
    assign bias_en   = (state == S_FINAL);
    assign out_en    = (state == S_OUT);
    assign busy      = (state != S_IDLE);

    // Pixel sequencing; a zero pass count behaves as a single pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            passes_q <= 8'd1;
            shift_q  <= '0;
            pass_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        passes_q <= (cfg_passes == '0) ? 8'd1 : cfg_passes;
                        shift_q  <= cfg_shift;
                        pass_cnt <= '0;
                        state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (acc_en) begin
                        pass_cnt <= pass_cnt + 8'd1;
                        if (last_beat)
                            state <= S_FINAL;
                    end
                end
                S_FINAL: state <= S_OUT;
                S_OUT:   state <= S_IDLE;
            endcase
        end
    end

    // Output strobe follows the OUT cycle by one edge, aligned with dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout_vld <= 1'b0;
        else
            dout_vld <= out_en;
    end

    // Sticky error: torn beats anywhere or full beats outside ACCUM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (mixed || (full_beat && state != S_ACCUM))
            err <= 1'b1;
        else if (start)
            err <= 1'b0;
    end

    for (genvar f = 0; f < O; f++) begin : g_lane
        psum_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (start),
            .acc_en  (acc_en),
            .bias_en (bias_en),
            .out_en  (out_en),
            .partial (partial[K*f +: K]),
            .bias    (bias[B_W*f +: B_W]),
            .shift   (shift_q),
            .dout    (dout[OUT_W*f +: OUT_W])
        );
    end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: randomized pixels against an
// arithmetic reference model, plus directed protocol/reset scenarios.
module tb_psum_accum;
    import psum_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic [7:0]         cfg_passes;
    logic [4:0]         cfg_shift;
    logic [B_W*O-1:0]   bias;
    logic [K*O-1:0]     partial;
    logic [O-1:0]       vld_i;
    logic [OUT_W*O-1:0] dout;
    logic               dout_vld;
    logic               busy;
    logic               err;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     lat;
    int     bt[256][O];
    int     bias_v[O];
    longint ref_acc[O];
    logic [OUT_W*O-1:0] exp_dout;

    psum_accum dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_passes (cfg_passes),
        .cfg_shift  (cfg_shift),
        .bias       (bias),
        .partial    (partial),
        .vld_i      (vld_i),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-half-up divide by 2^sh with floor semantics, then clamp.
    function automatic int ref_post(longint a, int sh);
        longint d;
        longint v;
        longint q;
        d = 1;
        repeat (sh) d = d * 2;
        v = a + ((sh > 0) ? d / 2 : 0);
        if (v >= 0) q = v / d;
        else q = -((-v + d - 1) / d);
        if (q < 0) return 0;
        if (q > 255) return 255;
        return int'(q);
    endfunction

    function automatic int rand_part();
        return int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21);
    endfunction

    function automatic int rand_bias();
        return int'($urandom_range(0, (1 << 16) - 1)) - (1 << 15);
    endfunction

    task automatic fill_rand(input int n);
        for (int b = 0; b < n; b++)
            for (int f = 0; f < O; f++) bt[b][f] = rand_part();
        for (int f = 0; f < O; f++) bias_v[f] = rand_bias();
    endtask

    task automatic start_px(input int p, input int sh);
        for (int f = 0; f < O; f++) begin
            ref_acc[f] = 0;
            bias[B_W*f +: B_W] = bias_v[f][B_W-1:0];
        end
        cfg_passes = p[7:0];
        cfg_shift  = sh[4:0];
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    task automatic do_beat(input int b, input logic [O-1:0] v, input bit add);
        for (int f = 0; f < O; f++) begin
            partial[K*f +: K] = bt[b][f][K-1:0];
            if (add) ref_acc[f] += bt[b][f];
        end
        vld_i = v;
        @(negedge clk);
        vld_i = '0;
    endtask

    task automatic wait_vld();
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            if (dout_vld) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_ref(input int sh);
        for (int f = 0; f < O; f++)
            exp_dout[OUT_W*f +: OUT_W] = 8'(ref_post(ref_acc[f] + bias_v[f], sh));
    endtask

    task automatic px(input int p, input int sh);
        int n;
        n = (p == 0) ? 1 : p;
        start_px(p, sh);
        for (int b = 0; b < n; b++) do_beat(b, '1, 1'b1);
        wait_vld();
        finish_ref(sh);
    endtask

    task automatic test_reset();
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
        checks++;
        if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_basic();
        logic [OUT_W*O-1:0] want;
        for (int f = 0; f < O; f++) begin
            bt[0][f] = 100;
            bias_v[f] = 0;
            want[OUT_W*f +: OUT_W] = 8'd100;
        end
        start_px(1, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        do_beat(0, '1, 1'b1);
        wait_vld();
        finish_ref(0);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
        checks++;
        if (dout !== want) begin errors++; $display("FAIL basic_dout: got %h want %h", dout, want); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", dout_vld); end
        checks++;
        if (dout !== want) begin errors++; $display("FAIL basic_hold: got %h want %h", dout, want); end
    endtask

    task automatic test_relu_round();
        fill_rand(4);
        bt[0][0] = 1000; bt[1][0] = -200; bt[2][0] = 50; bt[3][0] = -50;
        bias_v[0] = -800;
        px(4, 0);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL relu_dout: got %h want %h", dout, exp_dout); end
        checks++;
        if (dout[7:0] !== 8'd0) begin errors++; $display("FAIL relu_lane0: got %0d want 0", dout[7:0]); end
        @(negedge clk);
        fill_rand(4);
        for (int b = 0; b < 4; b++) bt[b][1] = 1000;
        bias_v[1] = 0;
        px(4, 4);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL shift4_dout: got %h want %h", dout, exp_dout); end
        checks++;
        if (dout[15:8] !== 8'd250) begin errors++; $display("FAIL shift4_lane1: got %0d want 250", dout[15:8]); end
    endtask

    task automatic test_sat_round();
        fill_rand(1);
        bt[0][0] = 1 << 20;
        bias_v[0] = 0;
        px(1, 0);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL sat_dout: got %h want %h", dout, exp_dout); end
        checks++;
        if (dout[7:0] !== 8'd255) begin errors++; $display("FAIL sat_lane0: got %0d want 255", dout[7:0]); end
        fill_rand(1);
        bt[0][0] = 24; bt[0][1] = 23; bt[0][2] = -24;
        bias_v[0] = 0; bias_v[1] = 0; bias_v[2] = 0;
        px(1, 4);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL round_dout: got %h want %h", dout, exp_dout); end
        checks++;
        if (dout[23:0] !== 24'h000102) begin errors++; $display("FAIL round_lanes: got %h want 000102", dout[23:0]); end
    endtask

    task automatic test_protocol();
        fill_rand(3);
        start_px(3, 0);
        do_beat(0, '1, 1'b1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL proto_err_clean: got %b want 0", err); end
        do_beat(1, 32'h0000_FFFF, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL proto_err_mixed: got %b want 1", err); end
        do_beat(1, '1, 1'b1);
        do_beat(2, '1, 1'b1);
        wait_vld();
        finish_ref(0);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL proto_latency: got %0d want 2", lat); end
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL proto_dout: got %h want %h", dout, exp_dout); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", err); end
        @(negedge clk);
        fill_rand(1);
        start_px(1, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL proto_start_clear: got %b want 0", err); end
        do_beat(0, '1, 1'b1);
        wait_vld();
        finish_ref(0);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL proto_dout2: got %h want %h", dout, exp_dout); end
        @(negedge clk);
        do_beat(0, '1, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL proto_idle_beat: got %b want 1", err); end
        checks++;
        if (dout !== exp_dout || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL proto_idle_hold: got %h vld %b want %h vld 0", dout, dout_vld, exp_dout);
        end
    endtask

    task automatic test_reset_mid();
        fill_rand(4);
        start_px(4, 2);
        do_beat(0, '1, 1'b1);
        do_beat(1, '1, 1'b1);
        do_beat(2, 32'h0000_0001, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got dout %h vld %b busy %b err %b want all 0",
                     dout, dout_vld, busy, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_rand(2);
        px(2, 3);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL midreset_latency: got %0d want 2", lat); end
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL midreset_dout: got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_back_to_back();
        longint t[3];
        for (int k = 0; k < 3; k++) begin
            fill_rand(2);
            px(2, k + 1);
            t[k] = cyc;
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL b2b_latency%0d: got %0d want 2", k, lat); end
            checks++;
            if (dout !== exp_dout) begin errors++; $display("FAIL b2b_dout%0d: got %h want %h", k, dout, exp_dout); end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t[k] - t[k-1] != 5) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d want 5", k, t[k] - t[k-1]);
            end
        end
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", dout_vld); end
    endtask

    task automatic test_random();
        int p;
        int sh;
        for (int k = 0; k < 8; k++) begin
            p  = (k == 0) ? 0 : int'($urandom_range(1, 8));
            sh = (k == 1) ? 31 : int'($urandom_range(0, 31));
            fill_rand((p == 0) ? 1 : p);
            px(p, sh);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL rand_latency%0d: got %0d want 2", k, lat); end
            checks++;
            if (dout !== exp_dout) begin errors++; $display("FAIL rand_dout%0d: got %h want %h", k, dout, exp_dout); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        fill_rand(255);
        px(255, 20);
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL rand_max_passes: got %h want %h", dout, exp_dout); end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_start  = 1'b0;
        cfg_passes = '0;
        cfg_shift  = '0;
        bias       = '0;
        partial    = '0;
        vld_i      = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_relu_round();
        test_sat_round();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
